// File: rtl/rtc_dhms_alarm.sv
// Day/hour/minute/second real-time counter with prescaler, validated load,
// alarm compare and rollover strobes. All outputs are registered.
module rtc_dhms_alarm #(
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned DAYS_PER_MONTH = 30,
  parameter int unsigned HRS_PER_DAY    = 24,
  parameter int unsigned MIN_PER_HR     = 60,
  parameter int unsigned SEC_PER_MIN    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_day,
  input  logic [4:0] load_hrs,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hrs,
  input  logic [5:0] alarm_min,
  input  logic [5:0] alarm_sec,
  output logic [4:0] day,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       alarm,
  output logic       load_err
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [4:0] DAY_MAX = 5'(DAYS_PER_MONTH);
  localparam logic [4:0] HRS_MAX = 5'(HRS_PER_DAY - 1);
  localparam logic [5:0] MIN_MAX = 6'(MIN_PER_HR - 1);
  localparam logic [5:0] SEC_MAX = 6'(SEC_PER_MIN - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [4:0] day_q, day_d, hrs_q, hrs_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic sec_tick_q, sec_tick_d, day_wrap_q, day_wrap_d;
  logic alarm_q, alarm_d, load_err_q, load_err_d;

  logic advance_c, load_ok_c, sec_max_c, min_max_c, hrs_max_c;

  assign advance_c = en && (pre_q == PRE_MAX);
  assign load_ok_c = (load_day != 5'd0) && (load_day <= DAY_MAX) &&
                     (load_hrs <= HRS_MAX) && (load_min <= MIN_MAX) &&
                     (load_sec <= SEC_MAX);
  assign sec_max_c = (sec_q == SEC_MAX);
  assign min_max_c = (min_q == MIN_MAX);
  assign hrs_max_c = (hrs_q == HRS_MAX);

  // Next-state: valid load wins over any advance due on the same edge
  always_comb begin
    pre_d      = pre_q;
    day_d      = day_q;
    hrs_d      = hrs_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    alarm_d    = 1'b0;
    load_err_d = load && !load_ok_c;
    if (load && load_ok_c) begin
      pre_d = '0;
      day_d = load_day;
      hrs_d = load_hrs;
      min_d = load_min;
      sec_d = load_sec;
    end else if (advance_c) begin
      pre_d      = '0;
      sec_tick_d = 1'b1;
      sec_d      = sec_max_c ? 6'd0 : sec_q + 6'd1;
      if (sec_max_c) begin
        min_d = min_max_c ? 6'd0 : min_q + 6'd1;
      end
      if (sec_max_c && min_max_c) begin
        hrs_d = hrs_max_c ? 5'd0 : hrs_q + 5'd1;
      end
      if (sec_max_c && min_max_c && hrs_max_c) begin
        if (day_q == DAY_MAX) begin
          day_d      = 5'd1;
          day_wrap_d = 1'b1;
        end else begin
          day_d = day_q + 5'd1;
        end
      end
      alarm_d = alarm_en && ({hrs_d, min_d, sec_d} == {alarm_hrs, alarm_min, alarm_sec});
    end else if (en) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      day_q      <= 5'd1;
      hrs_q      <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      day_q      <= day_d;
      hrs_q      <= hrs_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  assign day      = day_q;
  assign hrs      = hrs_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_rtc_dhms_alarm.sv
// Bench for rtc_dhms_alarm: CLK_DIV=1 and CLK_DIV=4 instances checked against
// a seconds-of-month reference model, directed steps then random traffic.
module tb_rtc_dhms_alarm;

  localparam int MONTH_S = 30 * 86400;

  logic clk, rst_n, en, load, alarm_en;
  logic [4:0] load_day, load_hrs, alarm_hrs;
  logic [5:0] load_min, load_sec, alarm_min, alarm_sec;

  logic [4:0] d1_day, d1_hrs, d4_day, d4_hrs;
  logic [5:0] d1_min, d1_sec, d4_min, d4_sec;
  logic d1_tick, d1_wrap, d1_alarm, d1_lerr;
  logic d4_tick, d4_wrap, d4_alarm, d4_lerr;

  int n_chk = 0;
  int n_pass = 0;

  // Model state per instance: index 0 -> CLK_DIV=1, index 1 -> CLK_DIV=4
  int div [2] = '{1, 4};
  int t [2];
  int pre [2];
  int e_tick [2], e_wrap [2], e_alarm [2], e_lerr [2];

  rtc_dhms_alarm #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .load_day(load_day), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
    .alarm_en(alarm_en), .alarm_hrs(alarm_hrs), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .day(d1_day), .hrs(d1_hrs), .min(d1_min), .sec(d1_sec),
    .sec_tick(d1_tick), .day_wrap(d1_wrap), .alarm(d1_alarm), .load_err(d1_lerr)
  );

  rtc_dhms_alarm #(.CLK_DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .load_day(load_day), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
    .alarm_en(alarm_en), .alarm_hrs(alarm_hrs), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .day(d4_day), .hrs(d4_hrs), .min(d4_min), .sec(d4_sec),
    .sec_tick(d4_tick), .day_wrap(d4_wrap), .alarm(d4_alarm), .load_err(d4_lerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    assert (obs === 32'(exp)) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; pre[i] = 0;
      e_tick[i] = 0; e_wrap[i] = 0; e_alarm[i] = 0; e_lerr[i] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs the DUT samples
  task automatic model_edge();
    bit ok;
    int alarm_t;
    ok = (load_day >= 1) && (load_day <= 30) && (load_hrs < 24) &&
         (load_min < 60) && (load_sec < 60);
    alarm_t = int'(alarm_hrs) * 3600 + int'(alarm_min) * 60 + int'(alarm_sec);
    for (int i = 0; i < 2; i++) begin
      e_tick[i] = 0; e_wrap[i] = 0; e_alarm[i] = 0;
      e_lerr[i] = (load && !ok) ? 1 : 0;
      if (load && ok) begin
        t[i] = (int'(load_day) - 1) * 86400 + int'(load_hrs) * 3600 +
               int'(load_min) * 60 + int'(load_sec);
        pre[i] = 0;
      end else if (en) begin
        if (pre[i] == div[i] - 1) begin
          pre[i] = 0;
          t[i] = (t[i] + 1) % MONTH_S;
          e_tick[i] = 1;
          e_wrap[i] = (t[i] == 0) ? 1 : 0;
          e_alarm[i] = (alarm_en && (t[i] % 86400 == alarm_t)) ? 1 : 0;
        end else begin
          pre[i]++;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [4:0] dy, input logic [4:0] hr,
                            input logic [5:0] mi, input logic [5:0] se, input logic tk,
                            input logic wr, input logic al, input logic le);
    string p;
    p = $sformatf("div%0d_", div[i]);
    chk({p, "day"}, 32'(dy), t[i] / 86400 + 1);
    chk({p, "hrs"}, 32'(hr), (t[i] / 3600) % 24);
    chk({p, "min"}, 32'(mi), (t[i] / 60) % 60);
    chk({p, "sec"}, 32'(se), t[i] % 60);
    chk({p, "sec_tick"}, 32'(tk), e_tick[i]);
    chk({p, "day_wrap"}, 32'(wr), e_wrap[i]);
    chk({p, "alarm"}, 32'(al), e_alarm[i]);
    chk({p, "load_err"}, 32'(le), e_lerr[i]);
  endtask

  task automatic check_all();
    check_inst(0, d1_day, d1_hrs, d1_min, d1_sec, d1_tick, d1_wrap, d1_alarm, d1_lerr);
    check_inst(1, d4_day, d4_hrs, d4_min, d4_sec, d4_tick, d4_wrap, d4_alarm, d4_lerr);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic do_load(input int d, input int h, input int m, input int s);
    load = 1'b1;
    load_day = 5'(d); load_hrs = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    step();
    load = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("arst_day", 32'(d1_day), 1);
    chk("arst_sec", 32'(d4_sec), 0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int tt;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; alarm_en = 1'b0;
    load_day = '0; load_hrs = '0; load_min = '0; load_sec = '0;
    alarm_hrs = '0; alarm_min = '0; alarm_sec = '0;
    model_reset();
    step(); step();
    rst_n = 1'b1;

    // Reach 3/05:10:20 region, then asynchronous reset between edges
    en = 1'b1;
    do_load(3, 5, 10, 20);
    chk("ld_hrs", 32'(d1_hrs), 5);
    step(); step();
    async_reset();

    // Full month rollover on the CLK_DIV=1 instance
    do_load(30, 23, 59, 58);
    step();
    chk("roll_pre_sec", 32'(d1_sec), 59);
    step();
    chk("roll_day", 32'(d1_day), 1);
    chk("roll_wrap", 32'(d1_wrap), 1);
    chk("roll_tick", 32'(d1_tick), 1);
    step();
    chk("roll_wrap_end", 32'(d1_wrap), 0);

    // Prescaler behaviour on the CLK_DIV=4 instance
    async_reset();
    repeat (3) begin
      step();
      chk("div4_hold_sec", 32'(d4_sec), 0);
    end
    step();
    chk("div4_first_sec", 32'(d4_sec), 1);
    chk("div4_first_tick", 32'(d4_tick), 1);
    step(); step();
    en = 1'b0;
    repeat (10) begin
      step();
      chk("frozen_tick", 32'(d4_tick), 0);
      chk("frozen_sec", 32'(d4_sec), 1);
    end
    en = 1'b1;
    step();

    // Load validation
    do_load(0, 1, 0, 0);
    chk("bad_day_err", 32'(d1_lerr), 1);
    do_load(5, 24, 0, 0);
    chk("bad_hrs_err", 32'(d4_lerr), 1);
    do_load(5, 23, 59, 59);
    chk("good_err", 32'(d1_lerr), 0);
    chk("good_day", 32'(d4_day), 5);

    // Load coincident with a due advance on the CLK_DIV=4 instance
    for (int k = 0; k < 8 && pre[1] != 3; k++) step();
    do_load(7, 12, 0, 0);
    chk("ldadv_tick", 32'(d4_tick), 0);
    chk("ldadv_sec", 32'(d4_sec), 0);

    // Alarm
    alarm_hrs = 5'd6; alarm_min = 6'd30; alarm_sec = 6'd0; alarm_en = 1'b1;
    do_load(2, 6, 29, 59);
    step();
    chk("alarm_hit", 32'(d1_alarm), 1);
    step();
    chk("alarm_one_cycle", 32'(d1_alarm), 0);
    alarm_en = 1'b0;
    do_load(2, 6, 29, 59);
    step();
    chk("alarm_disabled", 32'(d1_alarm), 0);
    alarm_en = 1'b1;
    do_load(2, 6, 30, 0);
    chk("alarm_on_load", 32'(d1_alarm), 0);
    repeat (6) step();

    // Randomised traffic
    repeat (3000) begin
      en = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: begin
          load_day = 5'($urandom_range(0, 31)); load_hrs = 5'($urandom_range(0, 31));
          load_min = 6'($urandom_range(0, 63)); load_sec = 6'($urandom_range(0, 63));
        end
        1: begin
          load_day = 5'(30); load_hrs = 5'(23); load_min = 6'(59);
          load_sec = 6'($urandom_range(50, 59));
        end
        default: begin
          load_day = 5'($urandom_range(1, 30)); load_hrs = 5'($urandom_range(0, 23));
          load_min = 6'($urandom_range(0, 59)); load_sec = 6'($urandom_range(0, 59));
        end
      endcase
      alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        tt = (t[$urandom_range(0, 1)] + int'($urandom_range(1, 4))) % 86400;
        alarm_hrs = 5'(tt / 3600); alarm_min = 6'((tt / 60) % 60); alarm_sec = 6'(tt % 60);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
